// File: rtl/mux32_arbiter.sv
// Purpose : two-requester round-robin arbiter driving a 2:1 word mux into a one-entry output register.
// Latency : valid in IDLE at cycle N -> ready at N+1 -> out_valid at N+2; 1 beat/cycle inside a grant.
// Backpr. : out_ready low holds the output register and drops the granted ready; the grant is held indefinitely.
//
// Ports
//   clk, reset_n                 rising-edge clock, asynchronous active-low reset
//   inX_valid/data/last/ready    requester X stream (X = 0, 1); ready only for the granted side
//   out_valid/data/src/last      registered selected beat; src names the requester it came from
//   out_ready                    downstream accepts the held beat
//   sel                          mux select, equal to the current grant (0 outside GRANT1)
//   busy                         arbiter is granting or still holds a beat
module mux32_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,

  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,

  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_last,
  input  logic             out_ready,

  output logic             sel,
  output logic             busy
);

  // Beat counter is sized so that MAX_BURST-1 is representable; it is cleared on
  // every release, so it never needs to hold MAX_BURST itself.
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_END = CW'(MAX_BURST - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_last_grant;
  logic [CW-1:0]    r_count;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;
  logic             r_out_last;

  logic             w_granted;
  logic             w_gsel;
  logic             w_load_en;
  logic             w_gnt_valid;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_gnt_last;
  logic             w_other_valid;
  logic             w_xfer;
  logic             w_burst_end;
  logic             w_release;

  assign w_granted = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
  assign w_gsel    = (r_state == ST_GRANT1);

  // The output register can take a new beat when it is empty or being drained now.
  assign w_load_en = !r_out_valid || out_ready;

  // Granted-side view of the inputs; only meaningful while w_granted is set.
  assign w_gnt_valid   = w_gsel ? in1_valid : in0_valid;
  assign w_gnt_data    = w_gsel ? in1_data  : in0_data;
  assign w_gnt_last    = w_gsel ? in1_last  : in0_last;
  assign w_other_valid = w_gsel ? in0_valid : in1_valid;

  assign w_xfer      = w_granted && w_gnt_valid && w_load_en;
  assign w_burst_end = (r_count == BURST_END);

  // A grant ends on a last beat, on the final allowed beat of the burst, or as soon
  // as the granted requester has nothing to send. A stall (valid but no load) keeps it.
  assign w_release = w_granted &&
                     (!w_gnt_valid || (w_xfer && (w_gnt_last || w_burst_end)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in0_valid && in1_valid) begin
          // Contention: favour whoever did not hold the most recent grant.
          w_state_nxt = r_last_grant ? ST_GRANT0 : ST_GRANT1;
        end else if (in0_valid) begin
          w_state_nxt = ST_GRANT0;
        end else if (in1_valid) begin
          w_state_nxt = ST_GRANT1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (w_release) begin
          // Hand straight over to a waiting peer; no IDLE bubble.
          if (w_other_valid) begin
            w_state_nxt = w_gsel ? ST_GRANT0 : ST_GRANT1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_count      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_release) begin
        r_last_grant <= w_gsel;
        r_count      <= '0;
      end else if (w_xfer) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  // Single-entry output stage. A load while the old beat drains replaces it in
  // the same cycle, keeping out_valid high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_src   <= w_gsel;
        // The final beat of a forced release is flagged as last downstream.
        r_out_last  <= w_gnt_last || w_burst_end;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in0_ready = (r_state == ST_GRANT0) && w_load_en;
  assign in1_ready = (r_state == ST_GRANT1) && w_load_en;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;

  assign sel  = w_gsel;
  assign busy = w_granted || r_out_valid;

endmodule

// File: tb/tb_mux32_arbiter.sv
module tb_mux32_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in0_valid, in0_last, in1_valid, in1_last, out_ready;
  logic [31:0] in0_data, in1_data;

  // Index 0: MAX_BURST = 4 instance, index 1: MAX_BURST = 1 instance.
  logic [1:0]  r0_o, r1_o, ov_o, os_o, ol_o, sel_o, busy_o;
  logic [31:0] od_o [2];

  mux32_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(r0_o[0]),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(r1_o[0]),
    .out_valid(ov_o[0]), .out_data(od_o[0]), .out_src(os_o[0]), .out_last(ol_o[0]),
    .out_ready(out_ready), .sel(sel_o[0]), .busy(busy_o[0])
  );

  mux32_arbiter #(.WIDTH(32), .MAX_BURST(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(r0_o[1]),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(r1_o[1]),
    .out_valid(ov_o[1]), .out_data(od_o[1]), .out_src(os_o[1]), .out_last(ol_o[1]),
    .out_ready(out_ready), .sel(sel_o[1]), .busy(busy_o[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (transaction rules, per instance) --------
  int          m_g     [2];   // current grant: -1 none, 0 or 1
  bit          m_lg    [2];   // requester that held the most recent grant
  int          m_beats [2];   // beats already moved in the current grant
  bit          m_ov    [2];
  logic [31:0] m_od    [2];
  bit          m_os    [2];
  bit          m_ol    [2];
  int          mb      [2] = '{4, 1};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_g[k] = -1; m_lg[k] = 1'b1; m_beats[k] = 0;
      m_ov[k] = 1'b0; m_od[k] = 32'h0; m_os[k] = 1'b0; m_ol[k] = 1'b0;
    end
  endtask

  task automatic model_check(input int k);
    bit le;
    le = !m_ov[k] || out_ready;
    chk($sformatf("m%0d_in0_ready", k), r0_o[k],  (m_g[k] == 0) && le);
    chk($sformatf("m%0d_in1_ready", k), r1_o[k],  (m_g[k] == 1) && le);
    chk($sformatf("m%0d_sel", k),       sel_o[k], m_g[k] == 1);
    chk($sformatf("m%0d_busy", k),      busy_o[k], (m_g[k] >= 0) || m_ov[k]);
    chk($sformatf("m%0d_out_valid", k), ov_o[k],  m_ov[k]);
    chk($sformatf("m%0d_out_data", k),  od_o[k],  m_od[k]);
    chk($sformatf("m%0d_out_src", k),   os_o[k],  m_os[k]);
    chk($sformatf("m%0d_out_last", k),  ol_o[k],  m_ol[k]);
  endtask

  task automatic model_step(input int k);
    bit le, v, l, other, x;
    logic [31:0] d;
    le = !m_ov[k] || out_ready;
    if (m_g[k] < 0) begin
      if (out_ready) m_ov[k] = 1'b0;
      if (in0_valid && in1_valid) m_g[k] = m_lg[k] ? 0 : 1;
      else if (in0_valid)         m_g[k] = 0;
      else if (in1_valid)         m_g[k] = 1;
    end else begin
      v     = (m_g[k] == 1) ? in1_valid : in0_valid;
      d     = (m_g[k] == 1) ? in1_data  : in0_data;
      l     = (m_g[k] == 1) ? in1_last  : in0_last;
      other = (m_g[k] == 1) ? in0_valid : in1_valid;
      x     = v && le;
      if (x) begin
        m_ov[k] = 1'b1; m_od[k] = d; m_os[k] = (m_g[k] == 1);
        m_ol[k] = l || (m_beats[k] + 1 == mb[k]);
        m_beats[k]++;
      end else if (out_ready) begin
        m_ov[k] = 1'b0;
      end
      if (!v || (x && (l || m_beats[k] == mb[k]))) begin
        m_lg[k] = (m_g[k] == 1); m_beats[k] = 0;
        m_g[k]  = other ? 1 - m_g[k] : -1;
      end
    end
  endtask

  // ---------------- helpers ---------------------------------------------------
  task automatic clear_inputs();
    in0_valid = 0; in0_data = 0; in0_last = 0;
    in1_valid = 0; in1_data = 0; in1_last = 0;
    out_ready = 0;
  endtask

  // Leaves time just after a rising edge with both instances idle ("cycle 0").
  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic i0v; logic [31:0] i0d; logic i0l;
    logic i1v; logic [31:0] i1d; logic i1l;
    logic ordy;
    logic e_r0; logic e_r1; logic e_sel; logic e_busy;
    logic e_ov; logic [31:0] e_od; logic e_os; logic e_ol;
  } vec_t;

  vec_t vt [7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single-beat transfers from each side, checked on the MAX_BURST = 4 instance.
    //          i0v  i0d           i0l  i1v  i1d           i1l  rdy  r0 r1 sel busy ov  od            os ol
    vt[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 0, 0, 0, 0, 0, 32'h0,        0, 0};
    vt[1] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1, 0, 0, 1, 0, 32'h0,        0, 0};
    vt[2] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 1};
    vt[3] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1};
    vt[4] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 0, 1, 1, 1, 0, 32'hDEADBEEF, 0, 1};
    vt[5] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 0, 0, 0, 1, 1, 32'h12345678, 1, 1};
    vt[6] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 0, 0, 0, 0, 0, 32'h12345678, 1, 1};

    // Reset values while reset is held.
    reset_n = 1'b0;
    clear_inputs();
    #2;
    chk("rst_out_valid", ov_o[0], 0);
    chk("rst_out_data",  od_o[0], 0);
    chk("rst_sel",       sel_o[0], 0);
    chk("rst_busy",      busy_o[0], 0);

    // ---- table vectors ----
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in0_valid = vt[i].i0v; in0_data = vt[i].i0d; in0_last = vt[i].i0l;
      in1_valid = vt[i].i1v; in1_data = vt[i].i1d; in1_last = vt[i].i1l;
      out_ready = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_in0_ready", i), r0_o[0],   vt[i].e_r0);
      chk($sformatf("vec%0d_in1_ready", i), r1_o[0],   vt[i].e_r1);
      chk($sformatf("vec%0d_sel", i),       sel_o[0],  vt[i].e_sel);
      chk($sformatf("vec%0d_busy", i),      busy_o[0], vt[i].e_busy);
      chk($sformatf("vec%0d_out_valid", i), ov_o[0],   vt[i].e_ov);
      chk($sformatf("vec%0d_out_data", i),  od_o[0],   vt[i].e_od);
      chk($sformatf("vec%0d_out_src", i),   os_o[0],   vt[i].e_os);
      chk($sformatf("vec%0d_out_last", i),  ol_o[0],   vt[i].e_ol);
      next_cycle();
    end

    // ---- continuous contention: 4-beat bursts (dut4) and strict alternation (dut1) ----
    do_reset();
    in0_valid = 1; in0_data = 32'h0A0; in1_valid = 1; in1_data = 32'h0B0; out_ready = 1;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (n >= 2) begin
        chk("burst_out_valid", ov_o[0], 1);
        chk("burst_out_src",   os_o[0], ((n - 2) / 4) % 2);
        chk("burst_out_last",  ol_o[0], ((n - 2) % 4) == 3);
        chk("burst_out_data",  od_o[0], (((n - 2) / 4) % 2 == 1) ? 32'h0B0 : 32'h0A0);
        chk("alt_out_valid",   ov_o[1], 1);
        chk("alt_out_src",     os_o[1], (n - 2) % 2);
        chk("alt_out_last",    ol_o[1], 1);
      end
      next_cycle();
    end

    // ---- in1 single last beat, in0 arrives during it: handover without bubble ----
    do_reset();
    in1_valid = 1; in1_data = 32'h00000001; in1_last = 1; out_ready = 1;
    @(negedge clk);
    chk("hand_c0_sel", sel_o[0], 0);
    next_cycle();
    in0_valid = 1; in0_data = 32'h22; in0_last = 1;
    @(negedge clk);
    chk("hand_c1_sel",       sel_o[0], 1);
    chk("hand_c1_in1_ready", r1_o[0], 1);
    chk("hand_c1_in0_ready", r0_o[0], 0);
    next_cycle();
    in1_valid = 0;
    @(negedge clk);
    chk("hand_c2_sel",       sel_o[0], 0);
    chk("hand_c2_in0_ready", r0_o[0], 1);
    chk("hand_c2_out_src",   os_o[0], 1);
    chk("hand_c2_out_data",  od_o[0], 32'h00000001);
    chk("hand_c2_out_last",  ol_o[0], 1);
    next_cycle();
    in0_valid = 0;
    @(negedge clk);
    chk("hand_c3_out_src",  os_o[0], 0);
    chk("hand_c3_out_data", od_o[0], 32'h22);
    next_cycle();

    // ---- downstream stall holds data and grant ----
    do_reset();
    in0_valid = 1; in0_data = 32'hA5A5A5A5; in1_valid = 1; in1_data = 32'h0B0B0B0B; out_ready = 1;
    next_cycle();
    @(negedge clk);
    chk("stall_c1_in0_ready", r0_o[0], 1);
    next_cycle();
    out_ready = 0; in0_data = 32'h5A5A5A5A;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_out_data",  od_o[0], 32'hA5A5A5A5);
      chk("stall_out_valid", ov_o[0], 1);
      chk("stall_in0_ready", r0_o[0], 0);
      chk("stall_in1_ready", r1_o[0], 0);
      chk("stall_sel",       sel_o[0], 0);
      next_cycle();
    end
    out_ready = 1;
    @(negedge clk);
    chk("unstall_in0_ready", r0_o[0], 1);
    chk("unstall_out_data",  od_o[0], 32'hA5A5A5A5);
    next_cycle();
    @(negedge clk);
    chk("unstall_next_data",  od_o[0], 32'h5A5A5A5A);
    chk("unstall_next_src",   os_o[0], 0);
    chk("unstall_next_valid", ov_o[0], 1);
    next_cycle();

    // ---- asynchronous reset in the middle of a burst ----
    do_reset();
    in0_valid = 1; in0_data = 32'h11; out_ready = 1;
    repeat (3) next_cycle();
    chk("midrst_pre_out_valid", ov_o[0], 1);
    #2;
    reset_n = 1'b0;
    in1_valid = 1;
    #1;
    chk("midrst_out_valid", ov_o[0], 0);
    chk("midrst_out_data",  od_o[0], 0);
    chk("midrst_out_src",   os_o[0], 0);
    chk("midrst_out_last",  ol_o[0], 0);
    chk("midrst_sel",       sel_o[0], 0);
    chk("midrst_in0_ready", r0_o[0], 0);
    chk("midrst_in1_ready", r1_o[0], 0);
    chk("midrst_busy",      busy_o[0], 0);
    @(negedge clk) reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("postrst_sel",       sel_o[0], 0);
    chk("postrst_in0_ready", r0_o[0], 1);
    chk("postrst_in1_ready", r1_o[0], 0);
    next_cycle();

    // ---- randomized traffic against the reference model, both instances ----
    do_reset();
    model_reset();
    repeat (1500) begin
      in0_valid = ($urandom_range(0, 3) != 0);
      in0_data  = $urandom;
      in0_last  = ($urandom_range(0, 3) == 0);
      in1_valid = ($urandom_range(0, 3) != 0);
      in1_data  = $urandom;
      in1_last  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_check(0);
      model_check(1);
      model_step(0);
      model_step(1);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
